// File: rtl/mem_initiator.sv
// mem_initiator: batches local register commands into one UDP request payload
// (8-octet header of seq and id, then 8-octet ctrl/addr/data records, MSB first),
// hands it to the Ethernet client tx mux, then parses the reply and returns
// read data.
// Optional build macro MEM_INITIATOR_TIMEOUT_EN enables the reply timeout
// counter and the timeout pulse; without it the block waits for a reply forever.
module mem_initiator #(
   parameter int          cmd_aw    = 5,
   parameter int          jumbo_dw  = 14,
   parameter int          timeout_w = 20,
   parameter logic [31:0] id        = 32'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_rd,
   input  logic [23:0]         cmd_addr,
   input  logic [31:0]         cmd_data,
   input  logic                cmd_last,
   output logic                tx_req,
   input  logic                tx_ack,
   input  logic                tx_strobe,
   output logic [jumbo_dw-1:0] tx_len,
   output logic [7:0]          packet_out,
   input  logic                rx_ready,
   input  logic                rx_strobe,
   input  logic [7:0]          packet_in,
   output logic                rsp_valid,
   output logic [23:0]         rsp_addr,
   output logic [31:0]         rsp_data,
   output logic                done,
   output logic                timeout,
   output logic                seq_mismatch,
   output logic                busy
);

   localparam int DEPTH = 2**cmd_aw;
   // octet counters must hold 8 + 8*DEPTH
   localparam int OW = cmd_aw + 4;
   localparam logic [cmd_aw:0] N_FULL = (cmd_aw+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_SEND = 3'd2,
      S_WAIT = 3'd3,
      S_RECV = 3'd4
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // command buffer
   logic        r_mem_rd   [DEPTH];
   logic [23:0] r_mem_addr [DEPTH];
   logic [31:0] r_mem_data [DEPTH];

   logic [cmd_aw:0]      r_n;
   logic [31:0]          r_seq;
   logic [jumbo_dw-1:0]  r_tx_len;
   logic [OW-1:0]        r_oct;
   logic [OW-1:0]        r_rx_cnt;
   logic                 r_rx_rd;
   logic [23:0]          r_rx_addr;
   logic [23:0]          r_rx_data;
   logic                 r_rsp_valid;
   logic [23:0]          r_rsp_addr;
   logic [31:0]          r_rsp_data;
   logic                 r_done;
   logic                 r_seq_mismatch;

   logic [cmd_aw:0]      w_n_inc;
   logic                 w_full;
   logic [OW-1:0]        w_total;
   logic [OW-1:0]        w_total_m1;
   logic [OW-1:0]        w_total_acc;
   logic                 w_accept;
   logic                 w_go;
   logic                 w_tx_last;
   logic                 w_rx_restart;
   logic                 w_rx_take;
   logic                 w_rx_hdr_bad;
   logic                 w_rx_end;
   logic                 w_to_hit;
   logic [cmd_aw-1:0]    w_tx_rec;
   logic [7:0]           w_tx_byte;

   // big-endian byte pick: idx 0 is the most significant octet
   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

   assign w_n_inc     = r_n + (cmd_aw+1)'(1);
   assign w_full      = (w_n_inc == N_FULL);
   assign w_total     = {r_n, 3'b000} + OW'(8);
   assign w_total_m1  = w_total - OW'(1);
   assign w_total_acc = {w_n_inc, 3'b000} + OW'(8);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // next-state decode and per-state qualifiers for the datapath
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_go         = 1'b0;
      w_tx_last    = 1'b0;
      w_rx_restart = 1'b0;
      w_rx_take    = 1'b0;
      w_rx_hdr_bad = 1'b0;
      w_rx_end     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = cmd_valid;
            w_go     = cmd_valid && (cmd_last || w_full);
            if (w_go) w_state_next = S_REQ;
         end
         S_REQ: begin
            if (tx_ack) w_state_next = S_SEND;
         end
         S_SEND: begin
            w_tx_last = tx_strobe && (r_oct == w_total_m1);
            if (w_tx_last) w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (w_to_hit) begin
               w_state_next = S_IDLE;
            end else if (rx_ready) begin
               w_rx_restart = 1'b1;
               w_state_next = S_RECV;
            end
         end
         S_RECV: begin
            if (w_to_hit) begin
               w_state_next = S_IDLE;
            end else if (rx_ready) begin
               w_rx_restart = 1'b1;
            end else if (rx_strobe) begin
               w_rx_take = 1'b1;
               if ((r_rx_cnt[OW-1:2] == '0) && (packet_in != byte_sel(r_seq, r_rx_cnt[1:0]))) begin
                  w_rx_hdr_bad = 1'b1;
                  w_state_next = S_WAIT;
               end else if (r_rx_cnt == w_total_m1) begin
                  w_rx_end     = 1'b1;
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // command buffer write, one record per accepted command
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_rd[r_n[cmd_aw-1:0]]   <= cmd_rd;
         r_mem_addr[r_n[cmd_aw-1:0]] <= cmd_addr;
         r_mem_data[r_n[cmd_aw-1:0]] <= cmd_data;
      end
   end

   // first-word-fall-through tx octet: header, then the current record
   always_comb begin
      w_tx_rec  = cmd_aw'(r_oct[OW-1:3] - (OW-3)'(1));
      w_tx_byte = 8'h00;
      if (r_state == S_SEND) begin
         if (r_oct[OW-1:3] == '0) begin
            w_tx_byte = r_oct[2] ? byte_sel(id, r_oct[1:0]) : byte_sel(r_seq, r_oct[1:0]);
         end else begin
            case (r_oct[2:0])
               3'd0:             w_tx_byte = {3'b000, r_mem_rd[w_tx_rec], 4'b0000};
               3'd1, 3'd2, 3'd3: w_tx_byte = byte_sel({8'h00, r_mem_addr[w_tx_rec]}, r_oct[1:0]);
               default:          w_tx_byte = r_mem_rd[w_tx_rec] ? 8'h00
                                             : byte_sel(r_mem_data[w_tx_rec], r_oct[1:0]);
            endcase
         end
      end
   end

   // batch bookkeeping, tx/rx octet counters, reply parsing and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_n            <= '0;
         r_seq          <= '0;
         r_tx_len       <= '0;
         r_oct          <= '0;
         r_rx_cnt       <= '0;
         r_rx_rd        <= 1'b0;
         r_rx_addr      <= '0;
         r_rx_data      <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_addr     <= '0;
         r_rsp_data     <= '0;
         r_done         <= 1'b0;
         r_seq_mismatch <= 1'b0;
      end else begin
         r_done         <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_seq_mismatch <= 1'b0;
         if (w_accept) r_n <= w_n_inc;
         if (w_go) begin
            r_tx_len <= jumbo_dw'(w_total_acc);
            r_oct    <= '0;
         end
         if ((r_state == S_SEND) && tx_strobe) r_oct <= r_oct + OW'(1);
         if (w_rx_restart) r_rx_cnt <= '0;
         if (w_rx_take) begin
            r_rx_cnt <= r_rx_cnt + OW'(1);
            // header octets 4..7 (id) carry nothing we need
            if (r_rx_cnt[OW-1:3] != '0) begin
               case (r_rx_cnt[2:0])
                  3'd0:             r_rx_rd   <= packet_in[4];
                  3'd1, 3'd2, 3'd3: r_rx_addr <= {r_rx_addr[15:0], packet_in};
                  3'd4, 3'd5, 3'd6: r_rx_data <= {r_rx_data[15:0], packet_in};
                  default: begin
                     if (r_rx_rd) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_addr  <= r_rx_addr;
                        r_rsp_data  <= {r_rx_data, packet_in};
                     end
                  end
               endcase
            end
         end
         if (w_rx_hdr_bad) r_seq_mismatch <= 1'b1;
         // a finished or abandoned exchange consumes one sequence number and the batch
         if (w_rx_end || w_to_hit) begin
            r_seq <= r_seq + 32'd1;
            r_n   <= '0;
         end
         if (w_rx_end) r_done <= 1'b1;
      end
   end

`ifdef MEM_INITIATOR_TIMEOUT_EN
   localparam logic [timeout_w-1:0] TO_PRE = ~timeout_w'(1);

   logic [timeout_w-1:0] r_to_cnt;
   logic                 r_timeout;

   // reply timer: runs only while waiting for or parsing a reply
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_to_hit;
         if ((r_state == S_WAIT) || (r_state == S_RECV)) r_to_cnt <= r_to_cnt + timeout_w'(1);
         else                                            r_to_cnt <= '0;
      end
   end

   // fires on the edge where the counter reaches all-ones
   assign w_to_hit = ((r_state == S_WAIT) || (r_state == S_RECV)) && (r_to_cnt == TO_PRE);
   assign timeout  = r_timeout;
`else
   assign w_to_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign tx_req       = (r_state == S_REQ);
   assign tx_len       = r_tx_len;
   assign packet_out   = w_tx_byte;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_addr     = r_rsp_addr;
   assign rsp_data     = r_rsp_data;
   assign done         = r_done;
   assign seq_mismatch = r_seq_mismatch;

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
Request-side counterpart of the UDP register gateway. It collects local register transactions into a batch and serializes them as one UDP payload: an 8-octet header, then 32-bit control+address / 32-bit data records, in network byte order. The packet is sent through the client tx handshake. The block then parses the returned packet, validates the sequence number and delivers read data. It sits between a local control master (soft CPU, test sequencer) and the Ethernet client mux.

Parameters:
cmd_aw, 5, log2 of command buffer depth; max records per packet = 2**cmd_aw
jumbo_dw, 14, width of tx_len
timeout_w, 20, width of reply timeout counter; timeout after 2**timeout_w-1 cycles in WAIT/RECV
id, 32'h0, constant sent as header octets 4..7

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_rd  in  1  1=read, 0=write
cmd_addr  in  24  register address
cmd_data  in  32  write data (ignored for reads)
cmd_last  in  1  closes batch and starts transmission
tx_req  out  1  packet available
tx_ack  in  1  one-cycle grant from tx mux
tx_strobe  in  1  consume current packet_out octet
tx_len  out  jumbo_dw  payload length in octets, valid while tx_req
packet_out  out  8  current tx octet
rx_ready  in  1  one-cycle pulse at start of received packet
rx_strobe  in  1  qualifies payload octets on packet_in
packet_in  in  8  received octet
rsp_valid  out  1  one-cycle read-data pulse
rsp_addr  out  24  address of returned read
rsp_data  out  32  read data
done  out  1  one-cycle pulse: matching reply fully parsed
timeout  out  1  one-cycle pulse: reply not received in time
seq_mismatch  out  1  one-cycle pulse: reply header seq differs, packet discarded
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; seq=0; buffer empty; all outputs 0 except cmd_ready=1.
- States: IDLE -> REQ -> SEND -> WAIT -> RECV -> IDLE.
- IDLE: cmd_ready=1. Each accept writes {rd,addr,data} at index n and increments n. Go to REQ on accept with cmd_last=1, or on the accept that fills the buffer (n reaches 2**cmd_aw). cmd_ready=0 in all other states.
- REQ: tx_req=1. tx_len = 8+8*n, registered on entry and stable. tx_ack -> tx_req=0 next cycle, go to SEND.
- SEND: packet_out is first-word-fall-through and holds octet k until a clk edge with tx_strobe=1.
- Octet order: seq[31:24..7:0], id[31:24..7:0], then per record: ctrl={3'b0,rd,4'b0}, addr[23:16], addr[15:8], addr[7:0], data[31:24..7:0]. Reads send data=0.
- After the last octet is consumed, go to WAIT and clear the timeout counter. tx_strobe in other states is ignored and packet_out=0.
- WAIT: rx_ready -> RECV with octet counter 0. Octets are counted only when rx_strobe=1.
- RECV octets 0..3 are compared to seq. On mismatch, pulse seq_mismatch, ignore the rest of the packet and return to WAIT; the timeout keeps running.
- RECV octets 4..7 are ignored.
- RECV records: capture ctrl+addr, then data. On the 4th data octet of a record with ctrl[4]=1, rsp_valid=1 the next cycle with rsp_addr and rsp_data. Write records produce no rsp.
- After 8+8*n octets, pulse done, seq<=seq+1, return to IDLE. Octets beyond that are ignored.
- A new rx_ready while in RECV restarts parsing at octet 0.
- Timeout: the counter runs in WAIT/RECV. On reaching all-ones, pulse timeout, seq<=seq+1, return to IDLE, and discard buffered commands.
- seq wraps 32'hFFFFFFFF -> 0.
- An empty batch is impossible because a batch always contains the accepting command.

Optional Feature:
MEM_INITIATOR_TIMEOUT_EN: when defined, the timeout counter and timeout pulse exist as above. When undefined, timeout is tied 0, WAIT/RECV wait indefinitely, and timeout_w is unused.

Test Plan:
- Single write addr 24'h000010 data 32'hDEADBEEF with cmd_last -> tx_len=16; octets 00 00 00 00, id, 00 00 00 10 DE AD BE EF; echo reply -> done, no rsp_valid, seq=1.
- Two reads 24'h000004, 24'h000008 -> ctrl octets 8'h10, tx_len=24; reply data 32'h11111111, 32'h22222222 -> two rsp_valid pulses in order with matching addr/data.
- 32 writes without cmd_last -> auto-start on the 32nd accept, tx_len=264; cmd_ready=0 until done.
- Reply with header seq 5 while expecting 0 -> seq_mismatch pulse, no rsp; correct reply afterwards -> done.
- With MEM_INITIATOR_TIMEOUT_EN, timeout_w=4 and no reply -> timeout 15 cycles after entering WAIT, busy=0, seq incremented.
- rst_n asserted mid-SEND -> tx_req=0, cmd_ready=1, seq=0 immediately; the next batch starts with seq 0.
